// File: rtl/cu_seq.sv
// Multicycle control sequencer: FETCH_COMM/FETCH_REG/FETCH_MEM/EXECUTE/HALT with memory wait states.
// Optional performance counters are built only when CU_PERF_EN is defined.
module cu_seq #(
  parameter int OPCODE_W = 5,
  parameter int MEM_WAIT = 0,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                s,
  input  logic                g,
  output logic                resultSrc, memWE, mem1RE, mem2RE, mem3RE, mem4RE,
  output logic                regWE, reg1RE, reg2RE, reg3RE, pcEn, op1RE, op2RE,
  output logic                RiRE, pcSrc, instrWrite, push, pop,
  output logic                illegal,
  output logic                halted,
  output logic [2:0]          D_STATE,
  output logic                D_SF,
  output logic                D_GF,
  output logic [CNT_W-1:0]    cycle_cnt,
  output logic [CNT_W-1:0]    instr_cnt
);

  typedef enum logic [2:0] {
    S_FETCH_COMM = 3'd0,
    S_FETCH_REG  = 3'd1,
    S_FETCH_MEM  = 3'd2,
    S_EXECUTE    = 3'd3,
    S_HALT       = 3'd4
  } state_t;

  localparam logic [3:0] WAIT_LD = 4'(MEM_WAIT);

  state_t     state_q, state_d;
  logic [3:0] wcnt_q, wcnt_d;
  logic       sf_q, sf_d, gf_q, gf_d;

  logic [4:0] op5;
  logic       legal, adv, ex_adv;
  logic       mem4_op, ex_wait_op, halt_op, sf_op, gf_op;

  // Opcodes wider than 5 bits are legal only with all upper bits clear.
  if (OPCODE_W > 5) begin : g_wide
    assign legal = ~|opcode[OPCODE_W-1:5];
  end else begin : g_narrow
    assign legal = 1'b1;
  end

  assign op5        = opcode[4:0];
  assign mem4_op    = legal & (op5 inside {5'h00, 5'h06, 5'h07, 5'h09, 5'h0B,
                                           5'h0E, 5'h0F, 5'h10, 5'h11});
  assign ex_wait_op = legal & (op5 inside {5'h01, 5'h02, 5'h03, 5'h04,
                                           5'h06, 5'h07, 5'h09, 5'h0B});
  assign halt_op    = legal & (op5 == 5'h13);
  assign sf_op      = legal & (op5 inside {[5'h05:5'h0C], 5'h12});
  assign gf_op      = legal & (op5 == 5'h11);

  assign adv    = ~stall & (wcnt_q == 4'd0);
  assign ex_adv = (state_q == S_EXECUTE) & adv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH_COMM;
      wcnt_q  <= WAIT_LD;
      sf_q    <= 1'b0;
      gf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      sf_q    <= sf_d;
      gf_q    <= gf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sf_d    = sf_q;
    gf_d    = gf_q;
    wcnt_d  = (wcnt_q != 4'd0) ? wcnt_q - 4'd1 : 4'd0;
    unique case (state_q)
      S_FETCH_COMM: if (adv) state_d = S_FETCH_REG;
      S_FETCH_REG:  state_d = S_FETCH_MEM;
      S_FETCH_MEM:  if (adv) state_d = S_EXECUTE;
      S_EXECUTE: begin
        if (adv) begin
          if (sf_op) sf_d = s;
          if (gf_op) gf_d = g;
          state_d = halt_op ? S_HALT : S_FETCH_COMM;
        end
      end
      S_HALT:       state_d = S_HALT;
      default:      state_d = S_FETCH_COMM;
    endcase
    // The wait counter is (re)armed only on the cycle a state is entered.
    if (state_d != state_q) begin
      unique case (state_d)
        S_FETCH_COMM: wcnt_d = WAIT_LD;
        S_FETCH_MEM:  wcnt_d = mem4_op ? WAIT_LD : 4'd0;
        S_EXECUTE:    wcnt_d = ex_wait_op ? WAIT_LD : 4'd0;
        default:      wcnt_d = 4'd0;
      endcase
    end
  end

  always_comb begin
    resultSrc  = 1'b0; memWE  = 1'b0; mem1RE = 1'b0; mem2RE = 1'b0;
    mem3RE     = 1'b0; mem4RE = 1'b0; regWE  = 1'b0; reg1RE = 1'b0;
    reg2RE     = 1'b0; reg3RE = 1'b0; pcEn   = 1'b0; op1RE  = 1'b0;
    op2RE      = 1'b0; RiRE   = 1'b0; pcSrc  = 1'b0; instrWrite = 1'b0;
    push       = 1'b0; pop    = 1'b0; illegal = 1'b0;
    unique case (state_q)
      S_FETCH_COMM: begin
        mem1RE = 1'b1;
        mem2RE = 1'b1;
        mem3RE = 1'b1;
        if (adv) begin
          instrWrite = 1'b1;
          pcEn       = 1'b1;
        end
      end
      S_FETCH_REG: begin
        if (legal && (op5 inside {5'h02, 5'h06, 5'h07, 5'h09, 5'h0B})) begin
          reg2RE = 1'b1; reg3RE = 1'b1; RiRE = 1'b1;
        end
        if (legal && (op5 inside {5'h01, 5'h02, 5'h03, 5'h05, 5'h08,
                                  5'h0A, 5'h0C, 5'h11, 5'h12})) begin
          reg1RE = 1'b1; op1RE = 1'b1;
        end
        if (legal && (op5 inside {5'h07, 5'h09, 5'h0B})) begin
          reg1RE = 1'b1; op2RE = 1'b1;
        end
        if (legal && (op5 inside {5'h08, 5'h0A, 5'h0C})) begin
          reg2RE = 1'b1; op2RE = 1'b1;
        end
      end
      S_FETCH_MEM: begin
        mem4RE = mem4_op;
        op1RE  = mem4_op & (op5 != 5'h11);
        op2RE  = mem4_op & (op5 == 5'h11);
      end
      S_EXECUTE: begin
        // Side effects fire only on the advancing cycle so a stall never repeats them.
        if (adv) begin
          if (!legal) begin
            illegal = 1'b1;
          end else begin
            unique case (op5)
              5'h00:                      begin resultSrc = 1'b1; regWE = 1'b1; end
              5'h01, 5'h02:               begin resultSrc = 1'b1; memWE = 1'b1; end
              5'h03:                      begin push = 1'b1; resultSrc = 1'b1; end
              5'h04:                      begin pop = 1'b1; regWE = 1'b1; end
              5'h05, 5'h08, 5'h0A, 5'h0C,
              5'h12:                      regWE = 1'b1;
              5'h06, 5'h07, 5'h09, 5'h0B: memWE = 1'b1;
              5'h0E:                      begin pcEn = 1'b1; pcSrc = 1'b1; end
              5'h0F:                      begin pcEn = sf_q; pcSrc = sf_q; end
              5'h10:                      begin pcEn = gf_q; pcSrc = gf_q; end
              5'h11, 5'h13:               ;
              default:                    illegal = 1'b1;
            endcase
          end
        end
      end
      default: ;
    endcase
  end

  assign halted  = (state_q == S_HALT);
  assign D_STATE = state_q;
  assign D_SF    = sf_q;
  assign D_GF    = gf_q;

`ifdef CU_PERF_EN
  logic [CNT_W-1:0] cyc_q, ins_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_q <= '0;
      ins_q <= '0;
    end else begin
      if (state_q != S_HALT) cyc_q <= sat_inc(cyc_q);
      if (ex_adv)            ins_q <= sat_inc(ins_q);
    end
  end

  assign cycle_cnt = cyc_q;
  assign instr_cnt = ins_q;
`else
  assign cycle_cnt = '0;
  assign instr_cnt = '0;
  wire unused_ex_adv = ex_adv;
`endif

endmodule

// File: tb/tb_cu_seq.sv
// Directed bench for cu_seq: instance A (6-bit opcode, no waits) and instance B (MEM_WAIT=2).
module tb_cu_seq;

  localparam logic [17:0] RES = 18'h20000, MWE = 18'h10000, M1 = 18'h08000,
                          M2  = 18'h04000, M3  = 18'h02000, M4 = 18'h01000,
                          RWE = 18'h00800, R1  = 18'h00400, R2 = 18'h00200,
                          R3  = 18'h00100, PC  = 18'h00080, O1 = 18'h00040,
                          O2  = 18'h00020, RI  = 18'h00010, PS = 18'h00008,
                          IW  = 18'h00004, PU  = 18'h00002, PO = 18'h00001;
  localparam logic [17:0] M123 = M1 | M2 | M3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, stall_a, s_a, g_a;
  logic [5:0]  opcode_a;
  logic [17:0] en_a;
  logic        ill_a, hlt_a, sf_a, gf_a;
  logic [2:0]  st_a;
  logic [31:0] cc_a, ic_a;

  logic        rst_b, stall_b;
  logic [4:0]  opcode_b;
  logic [17:0] en_b;
  logic        ill_b, hlt_b, sf_b, gf_b;
  logic [2:0]  st_b;
  logic [31:0] cc_b, ic_b;

  int n_checks = 0;
  int n_errors = 0;

  cu_seq #(.OPCODE_W(6), .MEM_WAIT(0), .CNT_W(32)) u_a (
    .clk(clk), .rst(rst_a), .stall(stall_a), .opcode(opcode_a), .s(s_a), .g(g_a),
    .resultSrc(en_a[17]), .memWE(en_a[16]), .mem1RE(en_a[15]), .mem2RE(en_a[14]),
    .mem3RE(en_a[13]), .mem4RE(en_a[12]), .regWE(en_a[11]), .reg1RE(en_a[10]),
    .reg2RE(en_a[9]), .reg3RE(en_a[8]), .pcEn(en_a[7]), .op1RE(en_a[6]),
    .op2RE(en_a[5]), .RiRE(en_a[4]), .pcSrc(en_a[3]), .instrWrite(en_a[2]),
    .push(en_a[1]), .pop(en_a[0]), .illegal(ill_a), .halted(hlt_a),
    .D_STATE(st_a), .D_SF(sf_a), .D_GF(gf_a), .cycle_cnt(cc_a), .instr_cnt(ic_a)
  );

  cu_seq #(.OPCODE_W(5), .MEM_WAIT(2), .CNT_W(32)) u_b (
    .clk(clk), .rst(rst_b), .stall(stall_b), .opcode(opcode_b), .s(1'b0), .g(1'b0),
    .resultSrc(en_b[17]), .memWE(en_b[16]), .mem1RE(en_b[15]), .mem2RE(en_b[14]),
    .mem3RE(en_b[13]), .mem4RE(en_b[12]), .regWE(en_b[11]), .reg1RE(en_b[10]),
    .reg2RE(en_b[9]), .reg3RE(en_b[8]), .pcEn(en_b[7]), .op1RE(en_b[6]),
    .op2RE(en_b[5]), .RiRE(en_b[4]), .pcSrc(en_b[3]), .instrWrite(en_b[2]),
    .push(en_b[1]), .pop(en_b[0]), .illegal(ill_b), .halted(hlt_b),
    .D_STATE(st_b), .D_SF(sf_b), .D_GF(gf_b), .cycle_cnt(cc_b), .instr_cnt(ic_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic exp_a(input string tag, input logic [2:0] st, input logic [17:0] en);
    check({tag, "_state"}, st_a, st);
    check({tag, "_en"}, en_a, en);
  endtask

  task automatic exp_b(input string tag, input logic [2:0] st, input logic [17:0] en);
    check({tag, "_state"}, st_b, st);
    check({tag, "_en"}, en_b, en);
  endtask

  task automatic cyc;
    @(posedge clk);
    #2;
  endtask

  // From FETCH_COMM, walk instance A into EXECUTE with the given opcode and flag inputs.
  task automatic run_a(input logic [5:0] op, input logic sv, input logic gv);
    opcode_a = op;
    s_a      = sv;
    g_a      = gv;
    cyc; cyc; cyc;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst_a = 1'b0; rst_b = 1'b0; stall_a = 1'b1; stall_b = 1'b1;
    opcode_a = '0; opcode_b = '0; s_a = 1'b0; g_a = 1'b0;
    #1;
    rst_a = 1'b1; rst_b = 1'b1;
    cyc; cyc;
    #1;
    exp_a("rst_a", 3'd0, M123);
    check("rst_a_halted", hlt_a, 1'b0);
    check("rst_a_flags", {sf_a, gf_a, ill_a}, 3'b000);
    check("rst_a_cnt", {cc_a, ic_a}, 64'd0);
    exp_b("rst_b", 3'd0, M123);
    check("rst_b_misc", {hlt_b, sf_b, gf_b, ill_b}, 4'b0000);
    check("rst_b_cnt", {cc_b, ic_b}, 64'd0);

    // Instance B: wait states in FETCH_COMM and EXECUTE with opcode 01.
    rst_b = 1'b0; stall_b = 1'b0; opcode_b = 5'h01;
    #1;
    exp_b("b_fc0", 3'd0, M123);
    cyc; #1 exp_b("b_fc1", 3'd0, M123);
    cyc; #1 exp_b("b_fc2", 3'd0, M123 | IW | PC);
    cyc; #1 exp_b("b_fr", 3'd1, R1 | O1);
    cyc; #1 exp_b("b_fm", 3'd2, 18'h0);
    cyc; #1 exp_b("b_ex0", 3'd3, 18'h0);
    cyc; #1 exp_b("b_ex1", 3'd3, 18'h0);
    cyc; #1 exp_b("b_ex2", 3'd3, RES | MWE);
    cyc; #1 exp_b("b_back", 3'd0, M123);
    rst_b = 1'b1; stall_b = 1'b1;

    // Instance A: opcode 00 end to end.
    rst_a = 1'b0; stall_a = 1'b0; opcode_a = 6'h00;
    #1 exp_a("a00_fc", 3'd0, M123 | IW | PC);
    cyc; #1 exp_a("a00_fr", 3'd1, 18'h0);
    cyc; #1 exp_a("a00_fm", 3'd2, M4 | O1);
    cyc; #1 exp_a("a00_ex", 3'd3, RES | RWE);
    cyc; #1 exp_a("a00_back", 3'd0, M123 | IW | PC);

    // Opcode 03 stalled four cycles in EXECUTE: push exactly once.
    opcode_a = 6'h03;
    cyc; #1 exp_a("a03_fr", 3'd1, R1 | O1);
    cyc; #1 exp_a("a03_fm", 3'd2, 18'h0);
    cyc;
    stall_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 exp_a("a03_stall", 3'd3, 18'h0);
      cyc;
    end
    stall_a = 1'b0;
    #1 exp_a("a03_push", 3'd3, PU | RES);
    cyc; #1 exp_a("a03_back", 3'd0, M123 | IW | PC);

    // Flags and conditional branches.
    run_a(6'h05, 1'b1, 1'b0);
    exp_a("a05_ex", 3'd3, RWE);
    cyc; #1 check("a05_sf1", sf_a, 1'b1);
    run_a(6'h0F, 1'b0, 1'b0);
    exp_a("a0f_taken", 3'd3, PC | PS);
    cyc; #1 check("a0f_sf_kept", sf_a, 1'b1);
    run_a(6'h05, 1'b0, 1'b0);
    cyc; #1 check("a05_sf0", sf_a, 1'b0);
    run_a(6'h0F, 1'b1, 1'b0);
    exp_a("a0f_not_taken", 3'd3, 18'h0);
    cyc; #1;
    run_a(6'h11, 1'b0, 1'b1);
    cyc; #1 check("a11_gf1", gf_a, 1'b1);
    run_a(6'h10, 1'b0, 1'b0);
    exp_a("a10_taken", 3'd3, PC | PS);
    cyc; #1;

    // Illegal wide opcode: low bits look like 00 but nothing may be enabled.
    opcode_a = 6'h20;
    cyc; #1 exp_a("aill_fr", 3'd1, 18'h0);
    cyc; #1 exp_a("aill_fm", 3'd2, 18'h0);
    cyc; #1 exp_a("aill_ex", 3'd3, 18'h0);
    check("aill_pulse", ill_a, 1'b1);
    cyc; #1 exp_a("aill_back", 3'd0, M123 | IW | PC);
    check("aill_clear", ill_a, 1'b0);

    // HALT is sticky until reset.
    run_a(6'h13, 1'b0, 1'b0);
    exp_a("ahalt_ex", 3'd3, 18'h0);
    check("ahalt_noill", ill_a, 1'b0);
    cyc; #1 exp_a("ahalt_in", 3'd4, 18'h0);
    check("ahalt_flag", hlt_a, 1'b1);
    cyc; cyc; cyc;
    #1 exp_a("ahalt_stay", 3'd4, 18'h0);
    check("ahalt_flag_stay", hlt_a, 1'b1);
    rst_a = 1'b1;
    #1 check("arst_state", st_a, 3'd0);
    check("arst_halted", hlt_a, 1'b0);

    // Three back-to-back 00 instructions for the counters.
    opcode_a = 6'h00; stall_a = 1'b0;
    rst_a = 1'b0;
    repeat (12) cyc;
    #1 check("perf_state", st_a, 3'd0);
`ifdef CU_PERF_EN
    check("perf_instr", ic_a, 32'd3);
    check("perf_cycle", cc_a, 32'd12);
`else
    check("perf_instr", ic_a, 32'd0);
    check("perf_cycle", cc_a, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
